packet_scheduler: RTL
=====================

# packet_scheduler

Data-island packet arbiter for the pixel-clock domain, sitting directly upstream of the `hdmi` core's `packet_type` input and alongside the audio `buffer`. On every `packet_enable` pulse it picks the next packet type for the data island:
- Audio Clock Regeneration (ACR)
- AVI InfoFrame
- Audio InfoFrame
- Audio Sample
- Null

It also produces the pop strobe that drains one sample from the audio buffer. This replaces ad-hoc scheduling logic in board top levels, and adds periodic ACR and audio-urgency priority.

## Interface
Parameters:
- ACR_FRAME_PERIOD, 1, ACR is sent in one frame out of every N; legal range 1..255.
- URGENT_LEVEL, 8'd24, `audio_remaining` at or above this preempts InfoFrame scheduling.

Ports:
- clk_pixel  input  1  pixel clock; sole clock.
- reset_n  input  1  synchronous, active-low reset.
- cx  input  10  current pixel column from `hdmi`.
- cy  input  10  current line from `hdmi`.
- packet_enable  input  1  single-cycle pulse from `hdmi`: a data-island packet slot opens.
- audio_remaining  input  8  samples available in the audio buffer.
- packet_type  output  8  type of the packet for the slot; registered.
- audio_pop  output  1  combinational: `packet_enable && packet_type == 8'h02`; drives the buffer's `packet_enable`.
- frame_count  output  8  frame counter modulo ACR_FRAME_PERIOD; registered.
- schedule_done  output  1  high once all per-frame control packets for the current frame have been issued; registered.

## Operation
- FSM states: S_ACR, S_AVI, S_AIF, S_STREAM.
- Frame start is the cycle with `cx == 0 && cy == 0`. On frame start:
  - `frame_count` increments, wrapping to 0 after ACR_FRAME_PERIOD-1.
  - The FSM enters S_ACR if the new `frame_count == 0`, else S_AVI.
  - `schedule_done` clears.
- On `packet_enable`, the pick is made in this priority order:
  1. If `audio_remaining >= URGENT_LEVEL` and state is not S_STREAM: pick 8'h02 and hold the state (urgent audio).
  2. S_ACR: pick 8'h01, go to S_AVI.
  3. S_AVI: pick 8'h82, go to S_AIF.
  4. S_AIF: pick 8'h84, go to S_STREAM, set `schedule_done`.
  5. S_STREAM: pick 8'h02 if `audio_remaining > 0`, else 8'h00.
- The pick is loaded into `packet_type` at the same edge that samples `packet_enable`.
- Reset values: `packet_type`=8'h00, state=S_ACR, `frame_count`=0, `schedule_done`=0. `audio_pop` is 0 while reset is asserted because `packet_type` is 0.
- Frame start and `packet_enable` in the same cycle: the frame-start state reset wins. The pick uses the post-reset state, so the slot gets ACR or AVI (or urgent audio).
- Reset asserted mid-frame: all state returns to reset values. Scheduling resumes at the next `packet_enable` in state S_ACR, without waiting for a frame start.
- `audio_remaining` is treated as unsigned. `audio_remaining == 0` never yields 8'h02.

## Timing
- Pick latency: `packet_type` is valid one cycle after the `packet_enable` edge and holds until the next `packet_enable`.
- `audio_pop` has zero latency: it is asserted in the `packet_enable` cycle when the held `packet_type` is 8'h02, i.e. the sample is consumed by the slot whose type was decided at the previous pulse.
- Consecutive `packet_enable` pulses may arrive back-to-back; every pulse makes exactly one pick.
- `frame_count` and `schedule_done` update on the edge following the triggering condition.

## Configuration
- Macro `PACKET_SCHEDULER_AVI_EN`.
- Defined: S_AVI is part of the rotation and emits 8'h82 as described.
- Undefined: S_AVI does not exist. S_ACR transitions directly to S_AIF, the frame-start path without ACR enters S_AIF, and 8'h82 is never emitted.

## Structure
- Shared package `hdmi_packet_pkg`:
  - packet type localparams: PKT_NULL=8'h00, PKT_ACR=8'h01, PKT_AUDIO=8'h02, PKT_AVI=8'h82, PKT_AIF=8'h84
  - the scheduler state enum typedef
- No sub-module: the FSM, frame counter and pop logic are a single module.

## Test plan
- Reset, then release; first `packet_enable` with `audio_remaining`=0 -> `packet_type`=8'h01, and `audio_pop` was 0 on that pulse.
- ACR_FRAME_PERIOD=1, `audio_remaining`=5, five pulses per frame -> types 01, 82, 84, 02, 02; `audio_pop` high on the 5th pulse; `schedule_done` high after the 3rd pulse.
- ACR_FRAME_PERIOD=3 over 6 frames -> 8'h01 appears only in frames with `frame_count`=0, i.e. frames 3 and 6 after reset (`frame_count` is 1 in the first frame after reset and is 0 in frames 3 and 6).
- `audio_remaining`=30 at frame start, URGENT_LEVEL=24 -> first two picks are 02, 02 with state held; after `audio_remaining` drops to 10, the next picks are 01, 82, 84.
- Frame start coincident with a `packet_enable` while in S_STREAM -> `packet_type` becomes 8'h01 or 8'h82 per `frame_count`, not 8'h02.
- Build without `PACKET_SCHEDULER_AVI_EN`, three pulses with `audio_remaining`=0 -> types 01, 84, 00; 8'h82 never observed.

Source files
------------

// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island definitions: packet type codes and scheduler state encoding.
// The S_AVI state exists only when PACKET_SCHEDULER_AVI_EN is defined.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AIF   = 8'h84;

`ifdef PACKET_SCHEDULER_AVI_EN
  typedef enum logic [1:0] {
    S_ACR    = 2'd0,
    S_AVI    = 2'd1,
    S_AIF    = 2'd2,
    S_STREAM = 2'd3
  } sched_state_t;
`else
  typedef enum logic [1:0] {
    S_ACR    = 2'd0,
    S_AIF    = 2'd2,
    S_STREAM = 2'd3
  } sched_state_t;
`endif

endpackage

// File: rtl/packet_scheduler.sv
// Data-island packet arbiter: picks ACR / AVI / Audio InfoFrame / audio / null per slot.
// Define PACKET_SCHEDULER_AVI_EN to include the AVI InfoFrame in the per-frame rotation.
module packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned ACR_FRAME_PERIOD = 1,
  parameter logic [7:0]  URGENT_LEVEL     = 8'd24
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  input  logic       packet_enable,
  input  logic [7:0] audio_remaining,
  output logic [7:0] packet_type,
  output logic       audio_pop,
  output logic [7:0] frame_count,
  output logic       schedule_done
);

  localparam logic [7:0] FC_LAST = 8'(ACR_FRAME_PERIOD - 1);

`ifdef PACKET_SCHEDULER_AVI_EN
  localparam sched_state_t S_AFTER_ACR = S_AVI;
`else
  localparam sched_state_t S_AFTER_ACR = S_AIF;
`endif

  // Handshake: packet_enable is a one-cycle slot strobe with no back-pressure; every
  // pulse commits exactly one pick, and audio_pop is the buffer's consume strobe for it.
  sched_state_t state;
  sched_state_t base_state;
  sched_state_t next_state;
  logic         frame_start;
  logic [7:0]   fc_next;
  logic [7:0]   pick;
  logic         pick_done;

  assign frame_start = (cx == 10'd0) && (cy == 10'd0);
  assign audio_pop   = packet_enable && (packet_type == PKT_AUDIO);

  // A frame start in the same cycle as a slot rewinds the state before the pick.
  always_comb begin
    fc_next    = (frame_count == FC_LAST) ? 8'd0 : frame_count + 8'd1;
    base_state = state;
    if (frame_start) begin
      base_state = (fc_next == 8'd0) ? S_ACR : S_AFTER_ACR;
    end
    next_state = base_state;
    pick       = PKT_NULL;
    pick_done  = 1'b0;
    if ((audio_remaining >= URGENT_LEVEL) && (base_state != S_STREAM)) begin
      pick = PKT_AUDIO;
    end else begin
      case (base_state)
        S_ACR: begin
          pick       = PKT_ACR;
          next_state = S_AFTER_ACR;
        end
`ifdef PACKET_SCHEDULER_AVI_EN
        S_AVI: begin
          pick       = PKT_AVI;
          next_state = S_AIF;
        end
`endif
        S_AIF: begin
          pick       = PKT_AIF;
          next_state = S_STREAM;
          pick_done  = 1'b1;
        end
        default: begin
          pick = (audio_remaining != 8'd0) ? PKT_AUDIO : PKT_NULL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state         <= S_ACR;
      packet_type   <= PKT_NULL;
      frame_count   <= 8'd0;
      schedule_done <= 1'b0;
    end else begin
      if (frame_start) begin
        frame_count   <= fc_next;
        schedule_done <= 1'b0;
        state         <= base_state;
      end
      if (packet_enable) begin
        packet_type <= pick;
        state       <= next_state;
        if (pick_done) begin
          schedule_done <= 1'b1;
        end
      end
    end
  end

endmodule
